// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings and data-processing decode for the multi-cycle ARM control unit
package arm_ctrl_pkg;

   localparam int ST_W = 4;

   // Control FSM states; encodings are visible on the State debug port
   typedef enum logic [ST_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   // ALU operation select
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Result mux select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RM   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Instruction class (Op field)
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing cmd field values
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   typedef struct packed {
      logic [1:0] alu_ctrl;
      logic [1:0] flag_w;
      logic       no_write;
   } dp_dec_t;

   // Unknown cmd values fall back to ADD so the datapath always does something defined
   function automatic dp_dec_t dp_decode(input logic [3:0] cmd, input logic s);
      dp_dec_t d;
      d.no_write = (cmd == CMD_CMP);
      case (cmd)
         CMD_SUB, CMD_CMP: d.alu_ctrl = ALU_SUB;
         CMD_AND:          d.alu_ctrl = ALU_AND;
         CMD_ORR:          d.alu_ctrl = ALU_ORR;
         default:          d.alu_ctrl = ALU_ADD;
      endcase
      if (!s) begin
         d.flag_w = 2'b00;
      end else if (d.alu_ctrl == ALU_AND || d.alu_ctrl == ALU_ORR) begin
         d.flag_w = 2'b10;
      end else begin
         d.flag_w = 2'b11;
      end
      return d;
   endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-field evaluation against the NZCV flags
module cond_check (
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       cond_ex_o
);

   logic n, z, c, v, ge;

   assign {n, z, c, v} = nzcv_i;
   assign ge = (n == v);

   // Condition table; 1111 is treated as never
   always_comb begin
      cond_ex_o = 1'b0;
      case (cond_i)
         4'b0000: cond_ex_o = z;
         4'b0001: cond_ex_o = ~z;
         4'b0010: cond_ex_o = c;
         4'b0011: cond_ex_o = ~c;
         4'b0100: cond_ex_o = n;
         4'b0101: cond_ex_o = ~n;
         4'b0110: cond_ex_o = v;
         4'b0111: cond_ex_o = ~v;
         4'b1000: cond_ex_o = c & ~z;
         4'b1001: cond_ex_o = ~c | z;
         4'b1010: cond_ex_o = ge;
         4'b1011: cond_ex_o = ~ge;
         4'b1100: cond_ex_o = ~z & ge;
         4'b1101: cond_ex_o = z | ~ge;
         4'b1110: cond_ex_o = 1'b1;
         default: cond_ex_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - sequencing FSM, decode and flag register for the multi-cycle ARM core
module multicycle_control_unit
   import arm_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic [19:0]        Instr,
   input  logic [3:0]         ALUFlags,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUCtrl,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         RegSrc,
   output logic [STATE_W-1:0] State
);

   state_t     state_q, state_d;
   logic [3:0] nzcv_q, nzcv_d;
   logic       condex_q, condex_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       i_bit, u_bit, l_bit, rd_pc;
   logic       cond_ex;
   logic       unused_rn;
   dp_dec_t    dec;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign funct     = Instr[13:8];
   assign rd        = Instr[3:0];
   assign unused_rn = ^Instr[7:4];

   assign i_bit = funct[5];
   assign u_bit = funct[3];
   assign l_bit = funct[0];
   assign rd_pc = (rd == 4'hF);
   assign dec   = dp_decode(funct[4:1], funct[0]);

   assign ImmSrc = op;
   assign RegSrc = {op == OP_MEM, op == OP_BR};
   assign State  = STATE_W'(state_q);

   cond_check u_cond_check (
      .cond_i    (cond),
      .nzcv_i    (nzcv_q),
      .cond_ex_o (cond_ex)
   );

   // State, flags and latched condition; reset returns to FETCH with flags cleared
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q  <= S_FETCH;
         nzcv_q   <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         nzcv_q   <= nzcv_d;
         condex_q <= condex_d;
      end
   end

   // Condition is frozen in DECODE so flag updates in EXECUTE cannot re-gate the same instruction
   always_comb begin
      nzcv_d   = nzcv_q;
      condex_d = condex_q;
      if (state_q == S_DECODE) begin
         condex_d = cond_ex;
      end
      if ((state_q == S_EXECR || state_q == S_EXECI) && condex_q) begin
         if (dec.flag_w[1]) nzcv_d[3:2] = ALUFlags[3:2];
         if (dec.flag_w[0]) nzcv_d[1:0] = ALUFlags[1:0];
      end
   end

   // Next-state and Moore datapath controls; strobes are forced low while Reset is held
   always_comb begin
      state_d   = S_FETCH;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_RM;
      ALUCtrl   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            AdrSrc    = 1'b0;
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ALUCtrl   = ALU_ADD;
            ResultSrc = RES_ALURES;
            PCWrite   = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_FOUR;
            ALUCtrl = ALU_ADD;
            case (op)
               OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_EXECR: begin
            ALUSrcA = 1'b0;
            ALUSrcB = SRCB_RM;
            ALUCtrl = dec.alu_ctrl;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 1'b0;
            ALUSrcB = SRCB_IMM;
            ALUCtrl = dec.alu_ctrl;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegWrite  = condex_q & ~dec.no_write;
            PCWrite   = condex_q & ~dec.no_write & rd_pc;
            state_d   = S_FETCH;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b0;
            ALUSrcB = SRCB_IMM;
            ALUCtrl = u_bit ? ALU_ADD : ALU_SUB;
            state_d = l_bit ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
            state_d   = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = condex_q;
            PCWrite   = condex_q & rd_pc;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = condex_q;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA   = 1'b0;
            ALUSrcB   = SRCB_IMM;
            ALUCtrl   = ALU_ADD;
            ResultSrc = RES_ALURES;
            PCWrite   = condex_q;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (!Reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multi-cycle control unit
module tb_multicycle_control_unit;
   import arm_ctrl_pkg::*;

   logic        clk;
   logic        Reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0]  ResultSrc, ALUSrcB, ALUCtrl, ImmSrc, RegSrc;
   logic [3:0]  State;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_control_unit #(.STATE_W(4)) dut (
      .clk       (clk),
      .Reset     (Reset),
      .Instr     (Instr),
      .ALUFlags  (ALUFlags),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUCtrl   (ALUCtrl),
      .ImmSrc    (ImmSrc),
      .RegSrc    (RegSrc),
      .State     (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One scoreboard entry per clock cycle: stimulus plus expected outputs (-1 = not checked)
   typedef struct {
      string       tag;
      logic        rst;
      logic [19:0] instr;
      logic [3:0]  flags;
      int          exp_v[10];
   } cyc_t;

   cyc_t  sb[$];
   string nm[10] = '{"State", "PCWrite", "AdrSrc", "MemWrite", "IRWrite",
                     "RegWrite", "ResultSrc", "ALUSrcA", "ALUSrcB", "ALUCtrl"};

   task automatic push(input string tag, input logic rst, input logic [19:0] i,
                       input logic [3:0] f, input int st, input int pcw, input int adr,
                       input int memw, input int irw, input int regw, input int rsrc,
                       input int srca, input int srcb, input int aluc);
      cyc_t c;
      c.tag   = $sformatf("%s[%05h]", tag, i);
      c.rst   = rst;
      c.instr = i;
      c.flags = f;
      c.exp_v = '{st, pcw, adr, memw, irw, regw, rsrc, srca, srcb, aluc};
      sb.push_back(c);
   endtask

   task automatic e_f(input logic [19:0] i);
      push("FETCH", 1, i, 0, S_FETCH, 1, 0, 0, 1, 0, 2, 1, 2, 0);
   endtask
   task automatic e_d(input logic [19:0] i);
      push("DECODE", 1, i, 0, S_DECODE, 0, -1, 0, 0, 0, -1, 1, 2, 0);
   endtask
   task automatic e_er(input logic [19:0] i, input logic [3:0] f, input int aluc);
      push("EXECR", 1, i, f, S_EXECR, 0, -1, 0, 0, 0, -1, 0, 0, aluc);
   endtask
   task automatic e_ei(input logic [19:0] i, input logic [3:0] f, input int aluc);
      push("EXECI", 1, i, f, S_EXECI, 0, -1, 0, 0, 0, -1, 0, 1, aluc);
   endtask
   task automatic e_aw(input logic [19:0] i, input int regw, input int pcw);
      push("ALUWB", 1, i, 0, S_ALUWB, pcw, -1, 0, 0, regw, 0, -1, -1, -1);
   endtask
   task automatic e_ma(input logic [19:0] i, input int aluc);
      push("MEMADR", 1, i, 0, S_MEMADR, 0, -1, 0, 0, 0, -1, 0, 1, aluc);
   endtask
   task automatic e_mr(input logic [19:0] i);
      push("MEMRD", 1, i, 0, S_MEMRD, 0, 1, 0, 0, 0, 0, -1, -1, -1);
   endtask
   task automatic e_mw(input logic [19:0] i, input int regw, input int pcw);
      push("MEMWB", 1, i, 0, S_MEMWB, pcw, -1, 0, 0, regw, 1, -1, -1, -1);
   endtask
   task automatic e_mwr(input logic [19:0] i, input int memw);
      push("MEMWR", 1, i, 0, S_MEMWR, 0, 1, memw, 0, 0, -1, -1, -1, -1);
   endtask
   task automatic e_br(input logic [19:0] i, input int pcw);
      push("BRANCH", 1, i, 0, S_BRANCH, pcw, -1, 0, 0, 0, 2, 0, 1, 0);
   endtask

   task automatic dp_seq(input logic [19:0] i, input logic imm, input logic [3:0] f,
                         input int aluc, input int regw, input int pcw);
      e_f(i);
      e_d(i);
      if (imm) e_ei(i, f, aluc);
      else     e_er(i, f, aluc);
      e_aw(i, regw, pcw);
   endtask
   task automatic ldr_seq(input logic [19:0] i, input int aluc, input int regw, input int pcw);
      e_f(i); e_d(i); e_ma(i, aluc); e_mr(i); e_mw(i, regw, pcw);
   endtask
   task automatic str_seq(input logic [19:0] i, input int aluc, input int memw);
      e_f(i); e_d(i); e_ma(i, aluc); e_mwr(i, memw);
   endtask
   task automatic br_seq(input logic [19:0] i, input int pcw);
      e_f(i); e_d(i); e_br(i, pcw);
   endtask

   // Drains the scoreboard: drive just after posedge, compare at negedge
   task automatic run_queue();
      cyc_t c;
      int   obs[10];
      while (sb.size() > 0) begin
         c        = sb.pop_front();
         Reset    = c.rst;
         Instr    = c.instr;
         ALUFlags = c.flags;
         @(negedge clk);
         obs = '{int'(State), int'(PCWrite), int'(AdrSrc), int'(MemWrite), int'(IRWrite),
                 int'(RegWrite), int'(ResultSrc), int'(ALUSrcA), int'(ALUSrcB), int'(ALUCtrl)};
         for (int k = 0; k < 10; k++) begin
            if (c.exp_v[k] >= 0) begin
               n_checks++;
               if (obs[k] != c.exp_v[k]) begin
                  n_errors++;
                  $display("FAIL %s %s: got %0d expected %0d", c.tag, nm[k], obs[k], c.exp_v[k]);
               end
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      Reset    = 1'b0;
      Instr    = 20'h00000;
      ALUFlags = 4'b0000;
      @(negedge clk);
      n_checks++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_strobes_c1: got %b expected 0000", {PCWrite, MemWrite, IRWrite, RegWrite});
      end
      @(negedge clk);
      n_checks++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_strobes_c2: got %b expected 0000", {PCWrite, MemWrite, IRWrite, RegWrite});
      end
      n_checks++;
      if (State !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_state: got %0d expected 0", State);
      end
   endtask

   task automatic test_decode();
      logic [19:0] ins[4] = '{20'hE0911, 20'hE5910, 20'h1A000, 20'hEC000};
      logic [1:0]  imm_e[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [1:0]  reg_e[4] = '{2'b00, 2'b10, 2'b01, 2'b00};
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         Instr = ins[k];
         #1;
         n_checks++;
         if (ImmSrc !== imm_e[k]) begin
            n_errors++;
            $display("FAIL ImmSrc[%05h]: got %b expected %b", ins[k], ImmSrc, imm_e[k]);
         end
         n_checks++;
         if (RegSrc !== reg_e[k]) begin
            n_errors++;
            $display("FAIL RegSrc[%05h]: got %b expected %b", ins[k], RegSrc, reg_e[k]);
         end
      end
      Instr = 20'h00000;
      @(posedge clk);
      #1;
   endtask

   // First instruction after release is ANDEQ R0: Z=0 after reset, so it must not write
   task automatic test_release();
      dp_seq(20'h00000, 0, 4'b0100, ALU_AND, 0, 0);
      run_queue();
   endtask

   task automatic test_adds();
      dp_seq(20'hE0911, 0, 4'b0100, ALU_ADD, 1, 0);
      dp_seq(20'h00812, 0, 4'b0000, ALU_ADD, 1, 0);
      dp_seq(20'h40812, 0, 4'b0000, ALU_ADD, 0, 0);
      dp_seq(20'h20812, 0, 4'b0000, ALU_ADD, 0, 0);
      run_queue();
   endtask

   task automatic test_mem();
      ldr_seq(20'hE5910, ALU_ADD, 1, 0);
      ldr_seq(20'hE5110, ALU_SUB, 1, 0);
      ldr_seq(20'hE591F, ALU_ADD, 1, 1);
      ldr_seq(20'h1591F, ALU_ADD, 0, 0);
      str_seq(20'hE5810, ALU_ADD, 1);
      str_seq(20'hE5010, ALU_SUB, 1);
      str_seq(20'h15810, ALU_ADD, 0);
      run_queue();
   endtask

   task automatic test_branch();
      br_seq(20'h1A000, 0);
      br_seq(20'h0A000, 1);
      dp_seq(20'hE0911, 0, 4'b0000, ALU_ADD, 1, 0);
      br_seq(20'h1A000, 1);
      br_seq(20'hEA000, 1);
      br_seq(20'hFA000, 0);
      run_queue();
   endtask

   task automatic test_cmp();
      dp_seq(20'hE3510, 1, 4'b0100, ALU_SUB, 0, 0);
      dp_seq(20'h00812, 0, 4'b0000, ALU_ADD, 1, 0);
      dp_seq(20'hE351F, 1, 4'b0100, ALU_SUB, 0, 0);
      run_queue();
   endtask

   task automatic test_flag_gating();
      dp_seq(20'h00911, 0, 4'b0010, ALU_ADD, 1, 0);
      dp_seq(20'h00812, 0, 4'b0000, ALU_ADD, 0, 0);
      dp_seq(20'h20812, 0, 4'b0000, ALU_ADD, 1, 0);
      dp_seq(20'h00911, 0, 4'b1101, ALU_ADD, 0, 0);
      dp_seq(20'h20812, 0, 4'b0000, ALU_ADD, 1, 0);
      dp_seq(20'h40812, 0, 4'b0000, ALU_ADD, 0, 0);
      dp_seq(20'hE0112, 0, 4'b1111, ALU_AND, 1, 0);
      dp_seq(20'h60812, 0, 4'b0000, ALU_ADD, 0, 0);
      dp_seq(20'h40812, 0, 4'b0000, ALU_ADD, 1, 0);
      dp_seq(20'hE1812, 0, 4'b0001, ALU_ORR, 1, 0);
      dp_seq(20'hE0412, 0, 4'b0001, ALU_SUB, 1, 0);
      dp_seq(20'hE1E12, 0, 4'b0001, ALU_ADD, 1, 0);
      dp_seq(20'hE2812, 1, 4'b0001, ALU_ADD, 1, 0);
      dp_seq(20'hE081F, 0, 4'b0000, ALU_ADD, 1, 1);
      dp_seq(20'hF0812, 0, 4'b0000, ALU_ADD, 0, 0);
      dp_seq(20'h60812, 0, 4'b0000, ALU_ADD, 0, 0);
      run_queue();
   endtask

   task automatic test_undef();
      e_f(20'hEC000);
      e_d(20'hEC000);
      dp_seq(20'hE0812, 0, 4'b0000, ALU_ADD, 1, 0);
      run_queue();
   endtask

   // Z=1 going in; reset during MEMWR must suppress the store and clear the flags
   task automatic test_reset_mid();
      e_f(20'hE5810);
      e_d(20'hE5810);
      e_ma(20'hE5810, ALU_ADD);
      push("MEMWR_RST", 0, 20'hE5810, 0, S_MEMWR, 0, -1, 0, 0, 0, -1, -1, -1, -1);
      dp_seq(20'h00812, 0, 4'b0000, ALU_ADD, 0, 0);
      dp_seq(20'h10812, 0, 4'b0000, ALU_ADD, 1, 0);
      run_queue();
   endtask

   task automatic test_back_to_back();
      br_seq(20'hEA000, 1);
      str_seq(20'hE5810, ALU_ADD, 1);
      ldr_seq(20'hE5910, ALU_ADD, 1, 0);
      e_f(20'hEC000);
      e_d(20'hEC000);
      dp_seq(20'hE3510, 1, 4'b0000, ALU_SUB, 0, 0);
      e_f(20'hE0812);
      run_queue();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_decode();
      test_release();
      test_adds();
      test_mem();
      test_branch();
      test_cmp();
      test_flag_gating();
      test_undef();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
